// File: rtl/mmm_pkg.sv
// mmm_pkg: shared types and constants for the branch resolution slice.
//   XLEN         datapath width
//   OFFSET       instruction-alignment bits dropped from stored targets
//   PQ_DEPTH_DEF default prediction queue depth
//   resolution_t resolved branch record sent to the BTB / predictor
//   pred_entry_t fetch-time prediction held in the queue
package mmm_pkg;

    localparam int XLEN         = 32;
    localparam int OFFSET       = 1;
    localparam int PQ_DEPTH_DEF = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
        logic            mispredict;
    } resolution_t;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic                   taken;
        logic [XLEN-OFFSET-1:0] target;
    } pred_entry_t;

    // Fall-through PC of a 4-byte control-transfer instruction.
    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// branch_resolver_if: decode, execute and BTB-update signals of the branch
// resolution unit.
//   master modport: the resolver (drives ready, update, redirect, error)
//   slave modport : the surrounding pipeline (drives predictions, outcomes, flush)
// With BRES_STATS_EN defined the interface also carries the two 32-bit
// statistics counters stat_branches_o and stat_mispred_o.
interface branch_resolver_if;
    import mmm_pkg::*;

    logic                   flush_i;
    logic                   pred_valid_i;
    logic                   pred_ready_o;
    logic [XLEN-1:0]        pred_pc_i;
    logic                   pred_taken_i;
    logic [XLEN-OFFSET-1:0] pred_target_i;
    logic                   exe_valid_i;
    logic [XLEN-1:0]        exe_pc_i;
    logic                   exe_taken_i;
    logic [XLEN-1:0]        exe_target_i;
    logic                   valid_o;
    logic                   del_entry_o;
    resolution_t            res_o;
    logic                   mispredict_o;
    logic [XLEN-1:0]        redirect_pc_o;
    logic                   err_o;
`ifdef BRES_STATS_EN
    logic [31:0]            stat_branches_o;
    logic [31:0]            stat_mispred_o;
`endif

    modport master (
        input  flush_i, pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i,
        input  exe_valid_i, exe_pc_i, exe_taken_i, exe_target_i,
        output pred_ready_o, valid_o, del_entry_o, res_o, mispredict_o,
        output redirect_pc_o, err_o
`ifdef BRES_STATS_EN
        , output stat_branches_o, stat_mispred_o
`endif
    );

    modport slave (
        output flush_i, pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i,
        output exe_valid_i, exe_pc_i, exe_taken_i, exe_target_i,
        input  pred_ready_o, valid_o, del_entry_o, res_o, mispredict_o,
        input  redirect_pc_o, err_o
`ifdef BRES_STATS_EN
        , input stat_branches_o, stat_mispred_o
`endif
    );

endinterface

// File: rtl/bres_fifo.sv
// bres_fifo: synchronous FIFO with a synchronous clear.
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           empties the FIFO; wins over push and pop in the same cycle
//   push, wr_data   write (ignored when full)
//   pop             discard head (ignored when empty)
//   rd_data         current head, valid while !empty
//   full, empty     status from the pointers
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module bres_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: holds fetch-time predictions of in-flight branches in an
// in-order queue, compares the oldest against the execute outcome, and emits a
// registered BTB update, a one-cycle mispredict pulse and the redirect PC.
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset
//   bus      branch_resolver_if.master: prediction enqueue, execute outcome,
//            flush, BTB update (valid_o/del_entry_o/res_o), mispredict_o,
//            redirect_pc_o, sticky err_o
// Optional feature: BRES_STATS_EN adds saturating resolution / mispredict
// counters (stat_branches_o, stat_mispred_o) cleared only by reset.
module branch_resolver
    import mmm_pkg::*;
#(
    parameter int PQ_DEPTH = PQ_DEPTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    branch_resolver_if.master  bus
);

    pred_entry_t     wr_entry;
    pred_entry_t     head;
    logic [$bits(pred_entry_t)-1:0] head_raw;
    logic            q_full;
    logic            q_empty;
    logic            q_push;
    logic            q_clear;
    logic            exe_fire;

    logic            pc_match;
    logic            eff_taken;
    logic            mispredict;
    logic            upd_valid;
    logic            upd_del;
    logic [XLEN-1:0] redirect_pc;

    logic            valid_q;
    logic            del_q;
    resolution_t     res_q;
    logic            mispredict_q;
    logic [XLEN-1:0] redirect_q;
    logic            err_q;

    assign wr_entry = '{pc: bus.pred_pc_i, taken: bus.pred_taken_i, target: bus.pred_target_i};
    assign head     = pred_entry_t'(head_raw);

    assign bus.pred_ready_o = !q_full;
    assign q_push   = bus.pred_valid_i && !q_full && !bus.flush_i;
    assign exe_fire = bus.exe_valid_i && !q_empty && !bus.flush_i;
    // Everything younger than a mispredicted branch is wrong-path, so the
    // queue is dropped together with the pop (and any same-cycle enqueue).
    assign q_clear  = bus.flush_i || (exe_fire && mispredict);

    bres_fifo #(
        .DEPTH (PQ_DEPTH),
        .WIDTH ($bits(pred_entry_t))
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .clear   (q_clear),
        .push    (q_push),
        .wr_data (wr_entry),
        .pop     (exe_fire),
        .rd_data (head_raw),
        .full    (q_full),
        .empty   (q_empty)
    );

    // A head that does not belong to the resolving PC carries no usable
    // prediction; resolve as if it had been predicted not-taken.
    always_comb begin
        pc_match    = (head.pc == bus.exe_pc_i);
        eff_taken   = pc_match && head.taken;
        mispredict  = (eff_taken != bus.exe_taken_i) ||
                      (bus.exe_taken_i && (head.target != bus.exe_target_i[XLEN-1:OFFSET]));
        upd_valid   = bus.exe_taken_i || eff_taken;
        upd_del     = !bus.exe_taken_i && eff_taken;
        redirect_pc = bus.exe_taken_i ? bus.exe_target_i : next_seq_pc(bus.exe_pc_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q      <= 1'b0;
            del_q        <= 1'b0;
            res_q        <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            err_q        <= 1'b0;
        end else if (bus.flush_i) begin
            valid_q      <= 1'b0;
            del_q        <= 1'b0;
            res_q        <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            del_q        <= 1'b0;
            mispredict_q <= 1'b0;
            if (bus.exe_valid_i) begin
                if (q_empty) begin
                    err_q <= 1'b1;
                end else begin
                    valid_q      <= upd_valid;
                    del_q        <= upd_del;
                    mispredict_q <= mispredict;
                    res_q        <= '{pc: bus.exe_pc_i, target: bus.exe_target_i,
                                      taken: bus.exe_taken_i, mispredict: mispredict};
                    redirect_q   <= redirect_pc;
                    if (!pc_match) err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.valid_o       = valid_q;
    assign bus.del_entry_o   = del_q;
    assign bus.res_o         = res_q;
    assign bus.mispredict_o  = mispredict_q;
    assign bus.redirect_pc_o = redirect_q;
    assign bus.err_o         = err_q;

`ifdef BRES_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispred_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else if (exe_fire) begin
            if (stat_branches_q != '1) stat_branches_q <= stat_branches_q + 32'd1;
            if (mispredict && (stat_mispred_q != '1)) stat_mispred_q <= stat_mispred_q + 32'd1;
        end
    end

    assign bus.stat_branches_o = stat_branches_q;
    assign bus.stat_mispred_o  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed self-checking bench for branch_resolver.
module tb_branch_resolver;
    import mmm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    branch_resolver_if bif ();

    branch_resolver #(.PQ_DEPTH(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bif)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.flush_i       = 1'b0;
        bif.pred_valid_i  = 1'b0;
        bif.pred_pc_i     = '0;
        bif.pred_taken_i  = 1'b0;
        bif.pred_target_i = '0;
        bif.exe_valid_i   = 1'b0;
        bif.exe_pc_i      = '0;
        bif.exe_taken_i   = 1'b0;
        bif.exe_target_i  = '0;
    endtask

    task automatic set_pred(input logic [XLEN-1:0] pc, input logic tk, input logic [XLEN-1:0] tgt);
        bif.pred_valid_i  = 1'b1;
        bif.pred_pc_i     = pc;
        bif.pred_taken_i  = tk;
        bif.pred_target_i = tgt[XLEN-1:OFFSET];
    endtask

    task automatic set_exe(input logic [XLEN-1:0] pc, input logic tk, input logic [XLEN-1:0] tgt);
        bif.exe_valid_i  = 1'b1;
        bif.exe_pc_i     = pc;
        bif.exe_taken_i  = tk;
        bif.exe_target_i = tgt;
    endtask

    task automatic enq(input logic [XLEN-1:0] pc, input logic tk, input logic [XLEN-1:0] tgt);
        set_pred(pc, tk, tgt);
        tick();
        bif.pred_valid_i = 1'b0;
    endtask

    task automatic resolve(input logic [XLEN-1:0] pc, input logic tk, input logic [XLEN-1:0] tgt);
        set_exe(pc, tk, tgt);
        tick();
        bif.exe_valid_i = 1'b0;
    endtask

    task automatic do_flush();
        bif.flush_i = 1'b1;
        tick();
        bif.flush_i = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bif.valid_o, 0);
        chk("rst_del", bif.del_entry_o, 0);
        chk("rst_misp", bif.mispredict_o, 0);
        chk("rst_err", bif.err_o, 0);
        chk("rst_res_pc", bif.res_o.pc, 0);
        chk("rst_res_tgt", bif.res_o.target, 0);
        chk("rst_redirect", bif.redirect_pc_o, 0);
        chk("rst_ready", bif.pred_ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // correctly predicted taken branch
        enq(32'h100, 1'b1, 32'h200);
        resolve(32'h100, 1'b1, 32'h200);
        chk("t1_valid", bif.valid_o, 1);
        chk("t1_del", bif.del_entry_o, 0);
        chk("t1_misp", bif.mispredict_o, 0);
        chk("t1_res_pc", bif.res_o.pc, 32'h100);
        chk("t1_res_tgt", bif.res_o.target, 32'h200);
        chk("t1_redirect", bif.redirect_pc_o, 32'h200);
        tick();
        chk("t1_valid_pulse", bif.valid_o, 0);

        // predicted taken, actually not taken
        enq(32'h100, 1'b1, 32'h200);
        resolve(32'h100, 1'b0, 32'h0);
        chk("t2_valid", bif.valid_o, 1);
        chk("t2_del", bif.del_entry_o, 1);
        chk("t2_misp", bif.mispredict_o, 1);
        chk("t2_redirect", bif.redirect_pc_o, 32'h104);
        tick();
        chk("t2_misp_pulse", bif.mispredict_o, 0);

        // fill to full (also shows the queue was empty after t2)
        enq(32'h10, 1'b0, 32'h0);
        enq(32'h20, 1'b0, 32'h0);
        enq(32'h30, 1'b0, 32'h0);
        chk("t3_ready_3", bif.pred_ready_o, 1);
        enq(32'h40, 1'b0, 32'h0);
        chk("t3_ready_full", bif.pred_ready_o, 0);
        set_exe(32'h10, 1'b0, 32'h0);
        set_pred(32'h50, 1'b0, 32'h0);
        #1;
        chk("t3_ready_popping", bif.pred_ready_o, 0);
        tick();
        idle();
        chk("t3_ready_after", bif.pred_ready_o, 1);
        chk("t3_nt_valid", bif.valid_o, 0);
        chk("t3_err", bif.err_o, 0);
        for (int i = 2; i <= 4; i++) begin
            resolve(XLEN'(i * 16), 1'b0, 32'h0);
            chk("t3_order_err", bif.err_o, 0);
        end
        // 0x50 was refused while full, so the queue is empty now
        resolve(32'h50, 1'b0, 32'h0);
        chk("t5_empty_err", bif.err_o, 1);
        chk("t5_empty_valid", bif.valid_o, 0);
        enq(32'h300, 1'b0, 32'h0);
        chk("t5_err_sticky", bif.err_o, 1);
        bif.flush_i = 1'b1;
        set_exe(32'h300, 1'b1, 32'h400);
        tick();
        idle();
        chk("t5_flush_valid", bif.valid_o, 0);
        chk("t5_flush_misp", bif.mispredict_o, 0);
        chk("t5_flush_err", bif.err_o, 0);
        chk("t5_flush_redirect", bif.redirect_pc_o, 0);
        resolve(32'h300, 1'b0, 32'h0);
        chk("t5_flush_emptied", bif.err_o, 1);
        do_flush();

        // pointer wrap: 10 simultaneous enqueue/pop pairs
        enq(32'h1000, 1'b1, 32'h2000);
        for (int k = 0; k < 10; k++) begin
            set_pred(XLEN'(32'h1000 + 4 * (k + 1)), 1'b1, XLEN'(32'h2000 + 8 * (k + 1)));
            set_exe(XLEN'(32'h1000 + 4 * k), 1'b1, XLEN'(32'h2000 + 8 * k));
            tick();
            idle();
            chk("wrap_misp", bif.mispredict_o, 0);
            chk("wrap_res_pc", bif.res_o.pc, 32'h1000 + 4 * k);
            chk("wrap_ready", bif.pred_ready_o, 1);
        end
        resolve(32'h1028, 1'b1, 32'h2050);
        chk("wrap_last_misp", bif.mispredict_o, 0);
        chk("wrap_last_valid", bif.valid_o, 1);
        chk("wrap_err", bif.err_o, 0);

        // mispredict with 3 queued and an enqueue in the same cycle
        enq(32'h500, 1'b0, 32'h0);
        enq(32'h504, 1'b0, 32'h0);
        enq(32'h508, 1'b0, 32'h0);
        set_pred(32'h50c, 1'b0, 32'h0);
        set_exe(32'h500, 1'b1, 32'h600);
        tick();
        idle();
        chk("t4_misp", bif.mispredict_o, 1);
        chk("t4_valid", bif.valid_o, 1);
        chk("t4_del", bif.del_entry_o, 0);
        chk("t4_redirect", bif.redirect_pc_o, 32'h600);
        enq(32'h10, 1'b0, 32'h0);
        enq(32'h20, 1'b0, 32'h0);
        enq(32'h30, 1'b0, 32'h0);
        chk("t4_cleared_ready", bif.pred_ready_o, 1);
        enq(32'h40, 1'b0, 32'h0);
        chk("t4_cleared_full", bif.pred_ready_o, 0);
        do_flush();

        // taken with wrong target
        enq(32'h900, 1'b1, 32'hA00);
        resolve(32'h900, 1'b1, 32'hA08);
        chk("tgt_misp", bif.mispredict_o, 1);
        chk("tgt_valid", bif.valid_o, 1);
        chk("tgt_del", bif.del_entry_o, 0);
        chk("tgt_res_tgt", bif.res_o.target, 32'hA08);
        chk("tgt_redirect", bif.redirect_pc_o, 32'hA08);

        // head PC mismatch: head treated as predicted not-taken
        enq(32'h700, 1'b1, 32'h800);
        resolve(32'h704, 1'b0, 32'h0);
        chk("pcmm_err", bif.err_o, 1);
        chk("pcmm_valid", bif.valid_o, 0);
        chk("pcmm_misp", bif.mispredict_o, 0);
        chk("pcmm_redirect", bif.redirect_pc_o, 32'h708);
        do_flush();

        // reset in the middle of operation
        enq(32'hB00, 1'b1, 32'hC00);
        enq(32'hB04, 1'b0, 32'h0);
        resolve(32'hB00, 1'b1, 32'hC00);
        chk("mrst_pre_valid", bif.valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", bif.valid_o, 0);
        chk("mrst_res_pc", bif.res_o.pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        resolve(32'hB04, 1'b0, 32'h0);
        chk("mrst_queue_gone", bif.err_o, 1);
        do_flush();

`ifdef BRES_STATS_EN
        chk("stat_rst_br", bif.stat_branches_o, 0);
        chk("stat_rst_mp", bif.stat_mispred_o, 0);
        for (int s = 0; s < 5; s++) begin
            enq(XLEN'(32'hD00 + 4 * s), 1'b1, 32'hE00);
            resolve(XLEN'(32'hD00 + 4 * s), (s == 1 || s == 3) ? 1'b0 : 1'b1, 32'hE00);
        end
        chk("stat_br", bif.stat_branches_o, 5);
        chk("stat_mp", bif.stat_mispred_o, 2);
        do_flush();
        chk("stat_br_flush", bif.stat_branches_o, 5);
        chk("stat_mp_flush", bif.stat_mispred_o, 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
